flash_array_ctrl: RTL and testbench

- Parametrised digital sequencer for a NAND-string flash array of NUM_STR strings × NUM_WL word lines × NUM_BL bit lines.
- Accepts READ, PROGRAM and ERASE commands over a valid/ready port and runs the timed select, precharge, two-phase sense, program-pulse and erase-pulse sequences on the array control lines.
- Captures sensed bit-line data into a page buffer and returns it, with status, over a valid/ready response port.
- Sits inside the user project wrapper between host-side logic and the analog array macro.

---
 rtl/flash_ctrl_pkg.sv | 36 +++
 rtl/flash_phase_timer.sv | 27 ++
 rtl/flash_array_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_flash_array_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/flash_ctrl_pkg.sv
// Shared encodings for the NAND-string flash array sequencer.
package flash_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ILLEGAL = 2'b00,
    OP_READ    = 2'b01,
    OP_PROGRAM = 2'b10,
    OP_ERASE   = 2'b11
  } flash_op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PRECHARGE,
    ST_SENSE1,
    ST_SENSE2,
    ST_PGM_PULSE,
    ST_ERASE_PULSE,
    ST_RECOVER,
    ST_RESP
  } flash_state_e;

  typedef enum logic [1:0] {
    WL_OFF     = 2'b00,
    WL_READ    = 2'b01,
    WL_PROGRAM = 2'b10,
    WL_ERASE   = 2'b11
  } wl_mode_e;

  localparam int unsigned RECOVER_CYCLES = 2;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/flash_phase_timer.sv
// Loadable phase down-counter; done_c is high once the count reaches zero.
module flash_phase_timer #(
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done_c
);

  logic [TW-1:0] cnt_q;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/flash_array_ctrl.sv
// Command sequencer for a NAND-string flash array (read / program / erase).
// Optional program-verify loop is built when FLASH_VERIFY_EN is defined.
module flash_array_ctrl
  import flash_ctrl_pkg::*;
#(
  parameter int unsigned NUM_BL        = 8,
  parameter int unsigned NUM_STR       = 2,
  parameter int unsigned NUM_WL        = 4,
  parameter int unsigned T_PRE         = 4,
  parameter int unsigned T_SENSE       = 8,
  parameter int unsigned T_PGM         = 64,
  parameter int unsigned T_ERS         = 256,
  parameter int unsigned MAX_PGM_LOOPS = 4,
  localparam int unsigned SW  = (NUM_STR > 1) ? $clog2(NUM_STR) : 1,
  localparam int unsigned WW  = (NUM_WL > 1) ? $clog2(NUM_WL) : 1,
  localparam int unsigned WLS = NUM_STR * NUM_WL
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [SW-1:0]     cmd_str_i,
  input  logic [WW-1:0]     cmd_wl_i,
  input  logic [NUM_BL-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [NUM_BL-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  output logic [NUM_STR-1:0] ssl_o,
  output logic [NUM_STR-1:0] gsl_o,
  output logic [WLS-1:0]    wl_sel_o,
  output logic [1:0]        wl_mode_o,
  output logic              bl_pre_o,
  output logic [NUM_BL-1:0] bl_drv_o,
  output logic              sl_en_o,
  output logic              vbpw_en_o,
  output logic              sen1_o,
  output logic              sen2_o,
  input  logic [NUM_BL-1:0] sense_i
);

  localparam int unsigned T_MAX = max2(max2(max2(T_PRE, T_SENSE), max2(T_PGM, T_ERS)), RECOVER_CYCLES);
  localparam int unsigned TW    = $clog2(T_MAX + 1);
  localparam int unsigned LW    = $clog2(MAX_PGM_LOOPS + 1);

  flash_state_e      state_q, state_d;
  flash_op_e         op_q, op_d;
  logic [SW-1:0]     str_q, str_d;
  logic [WW-1:0]     wl_q, wl_d;
  logic [NUM_BL-1:0] mask_q, mask_d;
  logic [LW-1:0]     loops_q, loops_d;
  logic              vfy_q, vfy_d;
  logic [NUM_BL-1:0] rdata_d;
  logic              err_d;

  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_done_c;

  logic              sel_d;
  logic [NUM_STR-1:0] ssl_d;
  logic [WLS-1:0]    wl_sel_d;
  wl_mode_e          wl_mode_d;
  logic [NUM_BL-1:0] bl_drv_d;
  logic              cmd_illegal_c;

  flash_phase_timer #(.TW(TW)) u_timer (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done_c   (tmr_done_c)
  );

  assign cmd_illegal_c = (cmd_op_i == OP_ILLEGAL) ||
                         (32'(cmd_str_i) >= NUM_STR) ||
                         ((cmd_op_i != OP_ERASE) && (32'(cmd_wl_i) >= NUM_WL));

  // Next state, command datapath and next value of every registered output.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    str_d     = str_q;
    wl_d      = wl_q;
    mask_d    = mask_q;
    loops_d   = loops_q;
    vfy_d     = vfy_q;
    rdata_d   = rsp_data_o;
    err_d     = rsp_err_o;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    sel_d     = 1'b0;
    ssl_d     = '0;
    wl_sel_d  = '0;
    wl_mode_d = WL_OFF;
    bl_drv_d  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          op_d    = flash_op_e'(cmd_op_i);
          str_d   = cmd_str_i;
          wl_d    = cmd_wl_i;
          mask_d  = cmd_data_i;
          loops_d = '0;
          vfy_d   = 1'b0;
          rdata_d = '0;
          err_d   = cmd_illegal_c;
          state_d = cmd_illegal_c ? ST_RESP : ST_SETUP;
        end
      end
      ST_SETUP: begin
        tmr_load = 1'b1;
        if (op_q == OP_ERASE) begin
          state_d = ST_ERASE_PULSE;
          tmr_val = TW'(T_ERS - 1);
        end else if (op_q == OP_PROGRAM) begin
          state_d = ST_PGM_PULSE;
          tmr_val = TW'(T_PGM - 1);
          loops_d = loops_q + LW'(1);
        end else begin
          state_d = ST_PRECHARGE;
          tmr_val = TW'(T_PRE - 1);
        end
      end
      ST_PRECHARGE: if (tmr_done_c) begin
        state_d  = ST_SENSE1;
        tmr_load = 1'b1;
        tmr_val  = TW'(T_SENSE - 1);
      end
      ST_SENSE1: if (tmr_done_c) begin
        state_d  = ST_SENSE2;
        tmr_load = 1'b1;
        tmr_val  = TW'(T_SENSE - 1);
      end
      ST_SENSE2: if (tmr_done_c) begin
        state_d  = ST_RECOVER;
        tmr_load = 1'b1;
        tmr_val  = TW'(RECOVER_CYCLES - 1);
        // Read returns the page; verify drops cells that stopped conducting.
        if (op_q == OP_READ) rdata_d = sense_i;
        else                 mask_d  = mask_q & sense_i;
      end
      ST_PGM_PULSE, ST_ERASE_PULSE: if (tmr_done_c) begin
        state_d  = ST_RECOVER;
        tmr_load = 1'b1;
        tmr_val  = TW'(RECOVER_CYCLES - 1);
      end
      ST_RECOVER: if (tmr_done_c) begin
        state_d = ST_RESP;
`ifdef FLASH_VERIFY_EN
        // Program alternates pulse and verify until the mask clears or loops run out.
        if (op_q == OP_PROGRAM) begin
          if (!vfy_q) begin
            state_d  = ST_PRECHARGE;
            vfy_d    = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = TW'(T_PRE - 1);
          end else if (mask_q != '0) begin
            if (loops_q < LW'(MAX_PGM_LOOPS)) begin
              state_d  = ST_PGM_PULSE;
              vfy_d    = 1'b0;
              loops_d  = loops_q + LW'(1);
              tmr_load = 1'b1;
              tmr_val  = TW'(T_PGM - 1);
            end else begin
              err_d   = 1'b1;
              rdata_d = mask_q;
            end
          end
        end
`endif
      end
      ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Array control decode from the state being entered.
    unique case (state_d)
      ST_SETUP: sel_d = 1'b1;
      ST_PRECHARGE, ST_SENSE1, ST_SENSE2: begin
        sel_d     = 1'b1;
        wl_mode_d = WL_READ;
        wl_sel_d  = WLS'(1) << (32'(str_d) * NUM_WL + 32'(wl_d));
      end
      ST_PGM_PULSE: begin
        sel_d     = 1'b1;
        wl_mode_d = WL_PROGRAM;
        wl_sel_d  = WLS'(1) << (32'(str_d) * NUM_WL + 32'(wl_d));
        bl_drv_d  = mask_d;
      end
      ST_ERASE_PULSE: begin
        sel_d     = 1'b1;
        wl_mode_d = WL_ERASE;
        wl_sel_d  = WLS'({NUM_WL{1'b1}}) << (32'(str_d) * NUM_WL);
      end
      default: sel_d = 1'b0;
    endcase
    if (sel_d) ssl_d = NUM_STR'(1) << str_d;
  end

  // State, command datapath and registered outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ILLEGAL;
      str_q       <= '0;
      wl_q        <= '0;
      mask_q      <= '0;
      loops_q     <= '0;
      vfy_q       <= 1'b0;
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
      ssl_o       <= '0;
      gsl_o       <= '0;
      wl_sel_o    <= '0;
      wl_mode_o   <= WL_OFF;
      bl_pre_o    <= 1'b0;
      bl_drv_o    <= '0;
      sl_en_o     <= 1'b0;
      vbpw_en_o   <= 1'b0;
      sen1_o      <= 1'b0;
      sen2_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      str_q       <= str_d;
      wl_q        <= wl_d;
      mask_q      <= mask_d;
      loops_q     <= loops_d;
      vfy_q       <= vfy_d;
      cmd_ready_o <= (state_d == ST_IDLE);
      busy_o      <= (state_d != ST_IDLE);
      rsp_valid_o <= (state_d == ST_RESP);
      rsp_data_o  <= rdata_d;
      rsp_err_o   <= err_d;
      ssl_o       <= ssl_d;
      gsl_o       <= ssl_d;
      wl_sel_o    <= wl_sel_d;
      wl_mode_o   <= wl_mode_d;
      bl_pre_o    <= (state_d == ST_PRECHARGE);
      bl_drv_o    <= bl_drv_d;
      sl_en_o     <= (state_d == ST_ERASE_PULSE);
      vbpw_en_o   <= (state_d == ST_ERASE_PULSE);
      sen1_o      <= (state_d == ST_SENSE1);
      sen2_o      <= (state_d == ST_SENSE2);
    end
  end

endmodule

// File: tb/tb_flash_array_ctrl.sv
// Directed bench for flash_array_ctrl: vector table plus reset / back-pressure sequences.
module tb_flash_array_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic       cmd_str = 1'b0;
  logic [1:0] cmd_wl = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  logic [1:0] ssl, gsl;
  logic [7:0] wl_sel;
  logic [1:0] wl_mode;
  logic       bl_pre;
  logic [7:0] bl_drv;
  logic       sl_en, vbpw_en, sen1, sen2;
  logic [7:0] sense = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  flash_array_ctrl dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_str_i   (cmd_str),
    .cmd_wl_i    (cmd_wl),
    .cmd_data_i  (cmd_data),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy),
    .ssl_o       (ssl),
    .gsl_o       (gsl),
    .wl_sel_o    (wl_sel),
    .wl_mode_o   (wl_mode),
    .bl_pre_o    (bl_pre),
    .bl_drv_o    (bl_drv),
    .sl_en_o     (sl_en),
    .vbpw_en_o   (vbpw_en),
    .sen1_o      (sen1),
    .sen2_o      (sen2),
    .sense_i     (sense)
  );

  typedef struct {
    logic [1:0] op;
    logic       str;
    logic [1:0] wl;
    logic [7:0] data;
    logic [7:0] sense;
    int         lat;
    logic [7:0] rdata;
    logic       err;
    logic [1:0] ssl;
    logic [7:0] wlsel;
    logic [1:0] mode;
    int         pre;
    int         sen;
    int         drv;
    logic [7:0] drv_or;
    int         ers;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic [1:0] op, input logic str, input logic [1:0] wl,
                               input logic [7:0] data, input logic [7:0] sns, input int lat,
                               input logic [7:0] rdata, input logic err, input logic [1:0] s,
                               input logic [7:0] wlsel, input logic [1:0] mode, input int pre,
                               input int sen, input int drv, input logic [7:0] drv_or, input int ers);
    vec_t v;
    v.op = op; v.str = str; v.wl = wl; v.data = data; v.sense = sns; v.lat = lat;
    v.rdata = rdata; v.err = err; v.ssl = s; v.wlsel = wlsel; v.mode = mode;
    v.pre = pre; v.sen = sen; v.drv = drv; v.drv_or = drv_or; v.ers = ers;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name, input int idx);
    check({name, "_arr"}, idx,
          32'({ssl, gsl, wl_sel, wl_mode, bl_pre, bl_drv, sl_en, vbpw_en, sen1, sen2}), 32'(0));
    check({name, "_rv"}, idx, 32'(rsp_valid), 32'(0));
    check({name, "_rdy_busy"}, idx, 32'({cmd_ready, busy}), 32'(2'b10));
  endtask

  // Issue one command and watch the array until the response arrives.
  task automatic run_vec(input int idx, input vec_t v);
    int lat, pre_c, sen_c, drv_c, ers_c, sl_c, excl_bad;
    logic [1:0] ssl_or, gsl_or, mode_or;
    logic [7:0] wls_or, drv_or;
    lat = 1; pre_c = 0; sen_c = 0; drv_c = 0; ers_c = 0; sl_c = 0; excl_bad = 0;
    ssl_or = '0; gsl_or = '0; mode_or = '0; wls_or = '0; drv_or = '0;
    cmd_op = v.op; cmd_str = v.str; cmd_wl = v.wl; cmd_data = v.data; sense = v.sense;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    check("ready_before", idx, 32'(cmd_ready), 32'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    forever begin
      ssl_or |= ssl; gsl_or |= gsl; wls_or |= wl_sel; mode_or |= wl_mode; drv_or |= bl_drv;
      if (bl_pre) pre_c++;
      if (sen1 || sen2) sen_c++;
      if (bl_drv != 8'h00) drv_c++;
      if (vbpw_en) ers_c++;
      if (sl_en) sl_c++;
      if (32'(bl_pre) + 32'(sen1) + 32'(sen2) + 32'(|bl_drv) + 32'(vbpw_en) > 1) excl_bad++;
      if (rsp_valid || lat >= 600) break;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", idx, 32'(lat), 32'(v.lat));
    check("rsp_data", idx, 32'(rsp_data), 32'(v.rdata));
    check("rsp_err", idx, 32'(rsp_err), 32'(v.err));
    check("ssl", idx, 32'(ssl_or), 32'(v.ssl));
    check("gsl", idx, 32'(gsl_or), 32'(v.ssl));
    check("wl_sel", idx, 32'(wls_or), 32'(v.wlsel));
    check("wl_mode", idx, 32'(mode_or), 32'(v.mode));
    check("pre_cycles", idx, 32'(pre_c), 32'(v.pre));
    check("sense_cycles", idx, 32'(sen_c), 32'(v.sen));
    check("drv_cycles", idx, 32'(drv_c), 32'(v.drv));
    check("drv_mask", idx, 32'(drv_or), 32'(v.drv_or));
    check("ers_cycles", idx, 32'(ers_c), 32'(v.ers));
    check("sl_cycles", idx, 32'(sl_c), 32'(v.ers));
    check("exclusive", idx, 32'(excl_bad), 32'(0));
    @(posedge clk); #1;
    check("rv_drop", idx, 32'({rsp_valid, cmd_ready}), 32'(2'b01));
  endtask

  initial begin
    int n;
    // op, str, wl, data, sense, lat, rdata, err, ssl, wlsel, mode, pre, sen, drv, drv_or, ers
    vecs.push_back(mkv(2'b01, 1'b1, 2'd2, 8'h00, 8'hA5, 24, 8'hA5, 1'b0, 2'b10, 8'h40, 2'b01, 4, 16, 0, 8'h00, 0));
    vecs.push_back(mkv(2'b01, 1'b0, 2'd0, 8'h00, 8'h3C, 24, 8'h3C, 1'b0, 2'b01, 8'h01, 2'b01, 4, 16, 0, 8'h00, 0));
    vecs.push_back(mkv(2'b01, 1'b0, 2'd3, 8'hFF, 8'h00, 24, 8'h00, 1'b0, 2'b01, 8'h08, 2'b01, 4, 16, 0, 8'h00, 0));
`ifdef FLASH_VERIFY_EN
    vecs.push_back(mkv(2'b10, 1'b0, 2'd3, 8'h0F, 8'h00, 90, 8'h00, 1'b0, 2'b01, 8'h08, 2'b11, 4, 16, 64, 8'h0F, 0));
    vecs.push_back(mkv(2'b10, 1'b1, 2'd0, 8'hF0, 8'h00, 90, 8'h00, 1'b0, 2'b10, 8'h10, 2'b11, 4, 16, 64, 8'hF0, 0));
    vecs.push_back(mkv(2'b10, 1'b0, 2'd3, 8'h0F, 8'hFF, 354, 8'h0F, 1'b1, 2'b01, 8'h08, 2'b11, 16, 64, 256, 8'h0F, 0));
`else
    vecs.push_back(mkv(2'b10, 1'b0, 2'd3, 8'h0F, 8'h00, 68, 8'h00, 1'b0, 2'b01, 8'h08, 2'b10, 0, 0, 64, 8'h0F, 0));
    vecs.push_back(mkv(2'b10, 1'b1, 2'd0, 8'hF0, 8'h00, 68, 8'h00, 1'b0, 2'b10, 8'h10, 2'b10, 0, 0, 64, 8'hF0, 0));
    vecs.push_back(mkv(2'b10, 1'b0, 2'd3, 8'h0F, 8'hFF, 68, 8'h00, 1'b0, 2'b01, 8'h08, 2'b10, 0, 0, 64, 8'h0F, 0));
`endif
    vecs.push_back(mkv(2'b11, 1'b1, 2'd0, 8'h00, 8'h00, 260, 8'h00, 1'b0, 2'b10, 8'hF0, 2'b11, 0, 0, 0, 8'h00, 256));
    vecs.push_back(mkv(2'b11, 1'b0, 2'd2, 8'hAA, 8'h00, 260, 8'h00, 1'b0, 2'b01, 8'h0F, 2'b11, 0, 0, 0, 8'h00, 256));
    vecs.push_back(mkv(2'b00, 1'b0, 2'd0, 8'h00, 8'hFF, 1, 8'h00, 1'b1, 2'b00, 8'h00, 2'b00, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mkv(2'b00, 1'b1, 2'd3, 8'hFF, 8'hFF, 1, 8'h00, 1'b1, 2'b00, 8'h00, 2'b00, 0, 0, 0, 8'h00, 0));

    // Reset state.
    #12;
    check_idle_outputs("reset", 0);
    check("reset_rsp", 0, 32'({rsp_data, rsp_err}), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset asserted during SENSE1 aborts the read with no response.
    cmd_op = 2'b01; cmd_str = 1'b1; cmd_wl = 2'd1; sense = 8'h5A; rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!sen1 && n < 50) begin @(posedge clk); #1; n++; end
    check("reach_sense1", 0, 32'(sen1), 32'(1));
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset", 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rsp_valid) n++;
    end
    check("no_rsp_after_abort", 0, 32'(n), 32'(0));
    check_idle_outputs("after_abort", 0);

    // Response back-pressure holds RESP.
    cmd_op = 2'b00; rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("hold_rsp", 0, 32'({rsp_valid, cmd_ready, busy, rsp_err}), 32'(4'b1011));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release", 0, 32'({rsp_valid, cmd_ready, busy}), 32'(3'b010));

    // Back-to-back: a read accepted right after the handshake.
    run_vec(100, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
